// File: rtl/image_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// image_mem_ctrl_if
//   Bundles the frame-memory controller's host write port, the read-request
//   handshake, the pixel output handshake, flush and the OOB counter.
//
//   Handshake rule for both the read-request channel (rd_valid/rd_ready) and
//   the pixel channel (pixel_out_valid/pixel_out_ready): a transfer happens on
//   a rising clock edge where valid and ready are both high; valid, once
//   raised by the producer, keeps its payload stable until that transfer.
//
//   Modports:
//     slave  - the controller (receives requests/writes, produces pixels)
//     master - the coordinate generator / pixel consumer side
// ---------------------------------------------------------------------------
interface image_mem_ctrl_if #(
    parameter int IMG_WIDTH   = 160,
    parameter int IMG_HEIGHT  = 120,
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic                   flush;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [XW-1:0]          rd_x;
    logic [YW-1:0]          rd_y;
    logic                   wr_en;
    logic [XW-1:0]          wr_x;
    logic [YW-1:0]          wr_y;
    logic [PIXEL_WIDTH-1:0] wr_data;
    logic                   pixel_out_valid;
    logic                   pixel_out_ready;
    logic [PIXEL_WIDTH-1:0] pixel_out;
    logic                   pixel_oob;
    logic [CNT_WIDTH-1:0]   oob_count;

    modport slave (
        input  flush, rd_valid, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, pixel_out_ready,
        output rd_ready, pixel_out_valid, pixel_out, pixel_oob, oob_count
    );

    modport master (
        output flush, rd_valid, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, pixel_out_ready,
        input  rd_ready, pixel_out_valid, pixel_out, pixel_oob, oob_count
    );
endinterface

// File: rtl/image_mem_ctrl.sv
// ---------------------------------------------------------------------------
// image_mem_ctrl
//   Frame memory with a single-cycle host write port and a two-stage,
//   back-pressurable read pipeline:
//     S1: synchronous RAM read + registered out-of-bounds flag
//     S2: output register (pixel_out / pixel_oob / pixel_out_valid)
//   A request handshaken in cycle N shows pixel_out_valid in cycle N+2.
//   Out-of-bounds reads skip the RAM, return OOB_VALUE with pixel_oob=1 and
//   bump a saturating counter. Out-of-bounds writes are dropped.
//   Memory contents are never reset; the frame is loaded over the write port.
//
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset (pipeline and counter only)
//   bus      - image_mem_ctrl_if.slave: flush, rd_* request channel, wr_*
//              write port, pixel_out* output channel, oob_count
// ---------------------------------------------------------------------------
module image_mem_ctrl #(
    parameter int                     IMG_WIDTH   = 160,
    parameter int                     IMG_HEIGHT  = 120,
    parameter int                     PIXEL_WIDTH = 8,
    parameter logic [PIXEL_WIDTH-1:0] OOB_VALUE   = '0,
    parameter int                     CNT_WIDTH   = 16
) (
    input logic              clk,
    input logic              reset_n,
    image_mem_ctrl_if.slave  bus
);
    localparam int XW    = $clog2(IMG_WIDTH);
    localparam int YW    = $clog2(IMG_HEIGHT);
    localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW    = $clog2(DEPTH);

    logic [PIXEL_WIDTH-1:0] mem [0:DEPTH-1];
    logic [PIXEL_WIDTH-1:0] ram_q;

    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_oob_q,   s1_oob_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [PIXEL_WIDTH-1:0] pix_q,      pix_d;
    logic                   pix_oob_q,  pix_oob_d;
    logic [CNT_WIDTH-1:0]   oob_cnt_q,  oob_cnt_d;

    logic          advance;
    logic          rd_ready;
    logic          accept;
    logic          rd_inb;
    logic          wr_inb;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;

    // Bounds checks are done one bit wider than the coordinate so that a
    // power-of-two dimension does not wrap to zero.
    assign rd_inb  = ({1'b0, bus.rd_x} < (XW+1)'(IMG_WIDTH)) &&
                     ({1'b0, bus.rd_y} < (YW+1)'(IMG_HEIGHT));
    assign wr_inb  = ({1'b0, bus.wr_x} < (XW+1)'(IMG_WIDTH)) &&
                     ({1'b0, bus.wr_y} < (YW+1)'(IMG_HEIGHT));
    assign rd_addr = AW'(bus.rd_y) * AW'(IMG_WIDTH) + AW'(bus.rd_x);
    assign wr_addr = AW'(bus.wr_y) * AW'(IMG_WIDTH) + AW'(bus.wr_x);

    // The whole pipeline moves together: it advances whenever the output
    // register is empty or being consumed. Flush blocks new requests.
    assign advance  = !pix_valid_q || bus.pixel_out_ready;
    assign rd_ready = advance && !bus.flush;
    assign accept   = bus.rd_valid && rd_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_oob_d    = s1_oob_q;
        pix_valid_d = pix_valid_q;
        pix_d       = pix_q;
        pix_oob_d   = pix_oob_q;
        oob_cnt_d   = oob_cnt_q;

        if (bus.flush) begin
            s1_valid_d  = 1'b0;
            pix_valid_d = 1'b0;
        end else if (advance) begin
            s1_valid_d  = accept;
            s1_oob_d    = !rd_inb;
            pix_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                pix_d     = s1_oob_q ? OOB_VALUE : ram_q;
                pix_oob_d = s1_oob_q;
            end
        end

        // accept is already gated by flush, so flush leaves the counter alone.
        if (accept && !rd_inb && (oob_cnt_q != '1)) begin
            oob_cnt_d = oob_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_oob_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_q       <= '0;
            pix_oob_q   <= 1'b0;
            oob_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_oob_q    <= s1_oob_d;
            pix_valid_q <= pix_valid_d;
            pix_q       <= pix_d;
            pix_oob_q   <= pix_oob_d;
            oob_cnt_q   <= oob_cnt_d;
        end
    end

    // RAM array and its read register carry no reset. Both statements use
    // non-blocking assignment, so a same-address read sees the old contents.
    // The read register only loads on an accepted in-bounds request, which
    // keeps S1 frozen while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (bus.wr_en && wr_inb) begin
            mem[wr_addr] <= bus.wr_data;
        end
        if (accept && rd_inb) begin
            ram_q <= mem[rd_addr];
        end
    end

    assign bus.rd_ready        = rd_ready;
    assign bus.pixel_out_valid = pix_valid_q;
    assign bus.pixel_out       = pix_q;
    assign bus.pixel_oob       = pix_oob_q;
    assign bus.oob_count       = oob_cnt_q;
endmodule
